// File: rtl/sm_disp_pkg.sv
// Shared types and 7-segment encodings for the sign-magnitude adder display controller.
// Segment vectors are active-low, bit 6 = a ... bit 0 = g.
package sm_disp_pkg;

    typedef enum logic [1:0] {
        SHOW_A   = 2'd0,
        SHOW_B   = 2'd1,
        SHOW_SUM = 2'd2
    } mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_b     = 7'h60;
    localparam logic [6:0] SEG_S     = 7'h24;

    function automatic logic [6:0] hex2seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h01;
            4'h1: seg = 7'h4F;
            4'h2: seg = 7'h12;
            4'h3: seg = 7'h06;
            4'h4: seg = 7'h4C;
            4'h5: seg = 7'h24;
            4'h6: seg = 7'h20;
            4'h7: seg = 7'h0F;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h04;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h60;
            4'hC: seg = 7'h31;
            4'hD: seg = 7'h42;
            4'hE: seg = 7'h30;
            default: seg = 7'h38;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sm_debounce.sv
// Counter-based debouncer for an already-synchronised level; emits a 1-cycle pulse
// on each debounced rising edge.
module sm_debounce #(
    parameter int unsigned DB_BITS = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise_pulse
);

    logic               last;
    logic [DB_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last       <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            if (din != last) begin
                last <= din;
                cnt  <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end else if (level != last) begin
                // Saturated and still differing from the output: accept the new level.
                level      <= last;
                rise_pulse <= last;
            end
        end
    end

endmodule

// File: rtl/sm_add_disp_ctrl.sv
// Sign-magnitude adder with mode-selected 4-digit multiplexed 7-segment display.
// Optional macro SM_AUTO_CYCLE_EN adds a periodic auto-advance of the display mode.
module sm_add_disp_ctrl
    import sm_disp_pkg::*;
#(
    parameter int unsigned N            = 8,
    parameter int unsigned DB_BITS      = 20,
    parameter int unsigned REFRESH_BITS = 18,
    parameter int unsigned AUTO_BITS    = 27
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2*N-1:0] sw,
    input  logic           btn_mode,
    output logic [3:0]     an,
    output logic [6:0]     sseg,
    output logic           dp
);

    localparam int unsigned M = N - 1;

    if (N < 4 || N > 9 || AUTO_BITS < 1 || REFRESH_BITS < 2) begin : g_bad_params
        $error("sm_add_disp_ctrl: illegal parameter value");
    end

    logic [2*N-1:0]        sw_s1, sw_s2;
    logic                  btn_s1, btn_s2;
    logic [N-1:0]          op_a, op_b;
    logic [N-1:0]          sum_r, sum_d;
    logic                  ovf_r, ovf_d;
    logic [REFRESH_BITS-1:0] refresh;
    logic                  btn_level, btn_rise, press, advance;
    mode_t                 mode, mode_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= btn_mode;
            btn_s2 <= btn_s1;
            op_a   <= sw_s2[N-1:0];
            op_b   <= sw_s2[2*N-1:N];
            sum_r  <= sum_d;
            ovf_r  <= ovf_d;
        end
    end

    logic         sa, sb;
    logic [M-1:0] ma, mb;
    logic [M:0]   mag_ext;

    always_comb begin
        sa      = op_a[N-1];
        sb      = op_b[N-1];
        ma      = op_a[M-1:0];
        mb      = op_b[M-1:0];
        mag_ext = {1'b0, ma} + {1'b0, mb};
        sum_d   = '0;
        ovf_d   = 1'b0;
        if (sa == sb) begin
            ovf_d = mag_ext[M];
            sum_d = {sa, mag_ext[M-1:0]};
        end else if (ma >= mb) begin
            sum_d = {sa, ma - mb};
        end else begin
            sum_d = {sb, mb - ma};
        end
        if (sum_d[M-1:0] == '0) begin
            sum_d[N-1] = 1'b0;
        end
    end

    sm_debounce #(
        .DB_BITS(DB_BITS)
    ) u_debounce (
        .clk       (clk),
        .reset_n   (reset_n),
        .din       (btn_s2),
        .level     (btn_level),
        .rise_pulse(btn_rise)
    );

    assign press = btn_rise & btn_level;

`ifdef SM_AUTO_CYCLE_EN
    logic [AUTO_BITS-1:0] auto_cnt;
    logic                 auto_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt <= '0;
        end else if (press) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign auto_tick = (auto_cnt == '1);
    // OR-ing the sources makes a coincident press and tick a single step.
    assign advance   = press | auto_tick;
`else
    assign advance   = press;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode <= SHOW_A;
        end else begin
            mode <= mode_nx;
        end
    end

    always_comb begin
        mode_nx = mode;
        if (advance) begin
            case (mode)
                SHOW_A:  mode_nx = SHOW_B;
                SHOW_B:  mode_nx = SHOW_SUM;
                default: mode_nx = SHOW_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh <= '0;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    logic [M-1:0] src_mag;
    logic         src_sign, src_ovf;
    logic [7:0]   mag8;
    logic [3:0]   an_d;
    logic [6:0]   seg_d;
    logic         dp_d;

    always_comb begin
        case (mode)
            SHOW_B: begin
                src_mag  = op_b[M-1:0];
                src_sign = op_b[N-1];
                src_ovf  = 1'b0;
            end
            SHOW_SUM: begin
                src_mag  = sum_r[M-1:0];
                src_sign = sum_r[N-1];
                src_ovf  = ovf_r;
            end
            default: begin
                src_mag  = op_a[M-1:0];
                src_sign = op_a[N-1];
                src_ovf  = 1'b0;
            end
        endcase
        mag8 = 8'(src_mag);

        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (refresh[REFRESH_BITS-1 -: 2])
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = hex2seg(mag8[3:0]);
                dp_d  = ~src_ovf;
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = hex2seg(mag8[7:4]);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = src_sign ? SEG_MINUS : SEG_BLANK;
            end
            default: begin
                an_d = 4'b0111;
                case (mode)
                    SHOW_B:   seg_d = SEG_b;
                    SHOW_SUM: seg_d = SEG_S;
                    default:  seg_d = SEG_A;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an   <= 4'b1111;
            sseg <= SEG_BLANK;
            dp   <= 1'b1;
        end else begin
            an   <= an_d;
            sseg <= seg_d;
            dp   <= dp_d;
        end
    end

endmodule

// File: tb/tb_sm_add_disp_ctrl.sv
// Scoreboard bench for sm_add_disp_ctrl: expected 4-digit frames are queued by the
// stimulus and compared by an independent monitor while the display scans.
module tb_sm_add_disp_ctrl;

    localparam int N  = 8;
    localparam int M  = N - 1;
    localparam int DB = 4;
    localparam int RB = 4;
    localparam int AB = 8;

    // Active-high abcdefg patterns for hex digits.
    localparam logic [6:0] HEX_ON [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef struct {
        logic [3:0][6:0] seg;
        logic [3:0]      dps;
        string           tag;
    } frame_t;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [2*N-1:0] sw = '0;
    logic           btn_mode = 1'b0;
    logic [3:0]     an;
    logic [6:0]     sseg;
    logic           dp;

    int             tests = 0;
    int             fails = 0;
    int             onehot_bad = 0;
    int             cyc = 0;
    int             mode_m = 0;
    logic [N-1:0]   cur_a = '0, cur_b = '0;
    frame_t         exp_q[$];

    always #5 clk = ~clk;

    sm_add_disp_ctrl #(
        .N(N),
        .DB_BITS(DB),
        .REFRESH_BITS(RB),
        .AUTO_BITS(AB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .btn_mode(btn_mode),
        .an      (an),
        .sseg    (sseg),
        .dp      (dp)
    );

    always @(posedge clk) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && cyc >= 2 && $countones(~an) != 1) onehot_bad++;
    end

    task automatic check(input string nm, input int unsigned act, input int unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input int md, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input string tag);
        frame_t f;
        int     ma, mb, va, vb, s, mag;
        bit     neg, ovf;
        ma  = int'(a[M-1:0]);
        mb  = int'(b[M-1:0]);
        ovf = 1'b0;
        if (md == 0) begin
            mag = ma; neg = a[N-1];
        end else if (md == 1) begin
            mag = mb; neg = b[N-1];
        end else begin
            va  = a[N-1] ? -ma : ma;
            vb  = b[N-1] ? -mb : mb;
            s   = va + vb;
            mag = (s < 0) ? -s : s;
            neg = (s < 0);
            ovf = (a[N-1] == b[N-1]) && (mag >= (1 << M));
            mag = mag % (1 << M);
            if (mag == 0) neg = 1'b0;
        end
        f.seg[0] = ~HEX_ON[mag & 15];
        f.seg[1] = ~HEX_ON[(mag >> 4) & 15];
        f.seg[2] = neg ? 7'h7E : 7'h7F;
        f.seg[3] = (md == 0) ? ~7'h77 : (md == 1) ? ~7'h1F : ~7'h5B;
        f.dps    = {3'b111, ~ovf};
        f.tag    = tag;
        return f;
    endfunction

    initial begin : monitor
        frame_t     f;
        logic [3:0] exp_an;
        int         n;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            f = exp_q[0];
            for (int k = 0; k < 4; k++) begin
                exp_an = ~(4'(1) << k);
                n = 0;
                while (an != exp_an && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("%s an%0d", f.tag, k), an, exp_an);
                check($sformatf("%s seg%0d", f.tag, k), sseg, f.seg[k]);
                check($sformatf("%s dp%0d", f.tag, k), dp, f.dps[k]);
            end
            void'(exp_q.pop_front());
        end
    end

    task automatic expect_frame(input string tag);
        int n;
        exp_q.push_back(make_frame(mode_m, cur_a, cur_b, tag));
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({tag, " drain"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic set_ops(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        cur_a = a;
        cur_b = b;
        sw    = {b, a};
        repeat (10) @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk);
        btn_mode = 1'b1;
        repeat (40) @(negedge clk);
        btn_mode = 1'b0;
        repeat (40) @(negedge clk);
        mode_m = (mode_m + 1) % 3;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        mode_m  = 0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        check("reset an", an, 4'hF);
        check("reset sseg", sseg, 7'h7F);
        check("reset dp", dp, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_frame("after_reset");

`ifdef SM_AUTO_CYCLE_EN
        while (cyc < 300) @(negedge clk);
        mode_m = 1;
        expect_frame("auto_B");
        while (cyc < 3 * 256 + 20) @(negedge clk);
        mode_m = 0;
        expect_frame("auto_wrap_A");
`else
        set_ops(8'h05, 8'h83);
        press();
        press();
        expect_frame("sum_05_83");
        set_ops(8'h03, 8'h85);
        expect_frame("sum_03_85");
        set_ops(8'h7F, 8'h01);
        expect_frame("sum_ovf");
        set_ops(8'h85, 8'h05);
        expect_frame("sum_zero");
        set_ops(8'h80, 8'h80);
        expect_frame("sum_negzero");

        for (int i = 0; i < 8; i++) begin
            set_ops(8'($urandom), 8'($urandom));
            expect_frame($sformatf("rand_sum%0d", i));
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_mode = 1'b1;
            repeat ($urandom_range(3, 10)) @(negedge clk);
            btn_mode = 1'b0;
            repeat ($urandom_range(3, 10)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        expect_frame("bounce_hold");

        for (int i = 0; i < 3; i++) begin
            press();
            set_ops(8'($urandom), 8'($urandom));
            expect_frame($sformatf("press_step%0d", i));
        end
        press();
        set_ops(8'h80, 8'h11);
        expect_frame("opA_negzero");

        @(negedge clk);
        btn_mode = 1'b1;
        repeat (10) @(negedge clk);
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        repeat (3) @(negedge clk);
        mode_m  = 0;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        expect_frame("reset_mid_press");
`endif

        check("one-hot an violations", onehot_bad, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
